// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the writeback arbiter.
package wb_pkg;
  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  typedef enum logic {
    PIPE  = 1'b0,
    FORCE = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - FIFO of long-latency results with a per-slot valid/rd view.
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  wb_entry_t                     push_entry_i,
  input  logic                          pop_i,
  output logic                          full_o,
  output logic                          empty_o,
  output wb_entry_t                     head_o,
  output logic [DEPTH-1:0]              entry_valid_o,
  output logic [DEPTH-1:0][REG_AW-1:0]  entry_rd_o
);
  localparam int AW = $clog2(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] off;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers are AW bits wide, so increments wrap modulo DEPTH for free.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

  // A slot is live when its distance from the read pointer is below the fill count.
  always_comb begin
    off           = '0;
    entry_valid_o = '0;
    entry_rd_o    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off              = AW'(i) - rd_ptr_q;
      entry_valid_o[i] = ({1'b0, off} < count_q);
      entry_rd_o[i]    = mem_q[i].rd;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write port arbiter (pipeline vs long-latency queue).
// WB_STARVE_EN enables the starvation counter and the one-cycle FORCE stall.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   pipe_read_data,
  input  logic [XLEN-1:0]   pipe_result,
  input  logic [REG_AW-1:0] pipe_rd,
  input  logic              pipe_memtoreg,
  input  logic              pipe_regwrite,
  input  logic              lu_valid,
  input  logic [REG_AW-1:0] lu_rd,
  input  logic [XLEN-1:0]   lu_data,
  output logic              lu_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              stall_pipe,
  output logic [31:0]       lu_pending
);
  logic                         pipe_live;
  logic                         q_full, q_empty, q_push, q_pop;
  logic                         force_sel;
  wb_entry_t                    q_head, lu_entry;
  logic [DEPTH-1:0]             q_valid;
  logic [DEPTH-1:0][REG_AW-1:0] q_rd;

  assign pipe_live = pipe_regwrite && (pipe_rd != '0);
  assign lu_ready  = !q_full;
  // Writes to x0 are accepted on the handshake but never occupy a slot.
  assign q_push    = lu_valid && lu_ready && (lu_rd != '0);
  assign lu_entry  = '{rd: lu_rd, data: lu_data};

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i         (clk),
    .rst_ni        (reset),
    .push_i        (q_push),
    .push_entry_i  (lu_entry),
    .pop_i         (q_pop),
    .full_o        (q_full),
    .empty_o       (q_empty),
    .head_o        (q_head),
    .entry_valid_o (q_valid),
    .entry_rd_o    (q_rd)
  );

`ifdef WB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  wb_state_e state_q, state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= PIPE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d      = PIPE;
    starve_cnt_d = starve_cnt_q;
    if (q_pop) begin
      starve_cnt_d = '0;
    end else if (!q_empty && (starve_cnt_q != CW'(STARVE_LIMIT))) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
    if ((state_q == PIPE) && (starve_cnt_d == CW'(STARVE_LIMIT))) state_d = FORCE;
  end

  assign force_sel = (state_q == FORCE);
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign force_sel = 1'b0;
`endif

  assign stall_pipe = force_sel;

  // The queue head wins when forced or when the pipeline has nothing to write.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    q_pop    = 1'b0;
    if (reset) begin
      if (force_sel || (!pipe_live && !q_empty)) begin
        rf_we    = 1'b1;
        rf_waddr = q_head.rd;
        rf_wdata = q_head.data;
        q_pop    = 1'b1;
      end else if (pipe_live) begin
        rf_we    = 1'b1;
        rf_waddr = pipe_rd;
        rf_wdata = pipe_memtoreg ? pipe_read_data : pipe_result;
      end
    end
  end

  always_comb begin
    lu_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[i]) lu_pending[q_rd[i]] = 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter against a queue-level model.
module tb_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
`ifdef WB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] pipe_read_data = '0, pipe_result = '0, lu_data = '0;
  logic [4:0]  pipe_rd = '0, lu_rd = '0;
  logic        pipe_memtoreg = 1'b0, pipe_regwrite = 1'b0, lu_valid = 1'b0;
  logic        lu_ready, rf_we, stall_pipe;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [31:0] lu_pending;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_read_data(pipe_read_data), .pipe_result(pipe_result), .pipe_rd(pipe_rd),
    .pipe_memtoreg(pipe_memtoreg), .pipe_regwrite(pipe_regwrite),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_pipe(stall_pipe), .lu_pending(lu_pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [4:0]  mq_rd[$];
  logic [63:0] mq_data[$];
  int          m_cnt = 0;
  bit          m_force = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq_rd.delete();
    mq_data.delete();
    m_cnt   = 0;
    m_force = 1'b0;
  endtask

  task automatic model_update();
    bit live, pop;
    int pre;
    if (!reset) begin
      model_clear();
      return;
    end
    live = pipe_regwrite && (pipe_rd != 5'd0);
    pre  = mq_rd.size();
    pop  = m_force || (!live && pre > 0);
    if (pop) begin
      mq_rd.delete(0);
      mq_data.delete(0);
    end
    if (lu_valid && pre < DEPTH && lu_rd != 5'd0) begin
      mq_rd.push_back(lu_rd);
      mq_data.push_back(lu_data);
    end
    if (STARVE_EN) begin
      if (pop) m_cnt = 0;
      else if (pre > 0) m_cnt = (m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1;
      m_force = !m_force && (m_cnt == LIMIT);
    end
  endtask

  task automatic compare();
    bit          live, ewe;
    logic [4:0]  ea;
    logic [63:0] ed;
    logic [31:0] ep;
    live = pipe_regwrite && (pipe_rd != 5'd0);
    ewe = 1'b0; ea = '0; ed = '0; ep = '0;
    if (m_force || (!live && mq_rd.size() > 0)) begin
      ewe = 1'b1; ea = mq_rd[0]; ed = mq_data[0];
    end else if (live) begin
      ewe = 1'b1; ea = pipe_rd; ed = pipe_memtoreg ? pipe_read_data : pipe_result;
    end
    foreach (mq_rd[i]) ep[mq_rd[i]] = 1'b1;
    chk("m_rf_we", rf_we, ewe);
    chk("m_rf_waddr", rf_waddr, ea);
    chk("m_rf_wdata", rf_wdata, ed);
    chk("m_stall", stall_pipe, m_force);
    chk("m_lu_ready", lu_ready, mq_rd.size() < DEPTH);
    chk("m_lu_pending", lu_pending, ep);
  endtask

  task automatic drive(input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                       input logic prw, input logic [4:0] prd, input logic pm,
                       input logic [63:0] prdata, input logic [63:0] pres);
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
    pipe_regwrite = prw; pipe_rd = prd; pipe_memtoreg = pm;
    pipe_read_data = prdata; pipe_result = pres;
  endtask

  task automatic step(input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                      input logic prw, input logic [4:0] prd, input logic pm,
                      input logic [63:0] prdata, input logic [63:0] pres);
    @(posedge clk);
    model_update();
    @(negedge clk);
    drive(lv, lrd, ld, prw, prd, pm, prdata, pres);
    #1;
    compare();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_stall"}, stall_pipe, 1'b0);
    chk({tag, "_we"}, rf_we, 1'b0);
    chk({tag, "_pending"}, lu_pending, 32'd0);
    chk({tag, "_ready"}, lu_ready, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_reset_outputs("rst");
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] got[$];
    bit c_acc;

    do_reset();

    // Idle pipe: queued result drains on the next cycle.
    step(1, 5, 64'hAA, 0, 0, 0, 0, 0);
    chk("idle_push_ready", lu_ready, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_we", rf_we, 1'b1);
    chk("idle_waddr", rf_waddr, 5'd5);
    chk("idle_wdata", rf_wdata, 64'hAA);
    chk("idle_pend_before", lu_pending[5], 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_pend_after", lu_pending, 32'd0);
    chk("idle_we_after", rf_we, 1'b0);

    // Load vs ALU select.
    step(0, 0, 0, 1, 3, 1, 64'h11, 64'h22);
    chk("load_waddr", rf_waddr, 5'd3);
    chk("load_wdata", rf_wdata, 64'h11);
    step(0, 0, 0, 1, 3, 0, 64'h11, 64'h22);
    chk("alu_wdata", rf_wdata, 64'h22);

    // x0 on both sources.
    step(1, 0, 64'h55, 1, 0, 1, 64'h66, 64'h77);
    chk("x0_we", rf_we, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_we_after", rf_we, 1'b0);
    chk("x0_pending", lu_pending, 32'd0);
    chk("x0_ready", lu_ready, 1'b1);

    // Starvation under a continuous pipe stream.
    do_reset();
    step(1, 7, 64'h77, 1, 1, 0, 0, 64'h100);
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 0, 1, 1, 0, 0, 64'h100 + 64'(k));
`ifdef WB_STARVE_EN
      chk("starve_stall", stall_pipe, k == 5);
      chk("starve_waddr", rf_waddr, (k == 5) ? 5'd7 : 5'd1);
`else
      chk("nostarve_stall", stall_pipe, 1'b0);
      chk("nostarve_waddr", rf_waddr, 5'd1);
`endif
    end
`ifndef WB_STARVE_EN
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("nostarve_drain", rf_waddr, 5'd7);
`endif

    // Full queue, third push waits for a pop, FIFO order.
    do_reset();
    step(1, 8, 64'h8, 1, 1, 0, 0, 64'h1);
    step(1, 9, 64'h9, 1, 1, 0, 0, 64'h1);
    c_acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(!c_acc, 10, 64'hA, i < 6, 1, 0, 0, 64'h1);
      if (i == 0) chk("full_ready", lu_ready, 1'b0);
      if (rf_we && rf_waddr != 5'd1) got.push_back(rf_waddr);
      if (!c_acc && lu_ready) begin
        c_acc = 1'b1;
        chk("third_after_pop", got.size() > 0, 1'b1);
      end
    end
    chk("third_accepted", c_acc, 1'b1);
    chk("fifo_count", got.size(), 3);
    chk("fifo_0", got.size() > 0 ? got[0] : 5'd0, 5'd8);
    chk("fifo_1", got.size() > 1 ? got[1] : 5'd0, 5'd9);
    chk("fifo_2", got.size() > 2 ? got[2] : 5'd0, 5'd10);

    // Reset with a queued entry (during FORCE when starvation is enabled).
    do_reset();
    step(1, 12, 64'hC, 1, 1, 0, 0, 64'h1);
    for (int k = 1; k <= 4; k++) step(0, 0, 0, 1, 1, 0, 0, 64'h1);
`ifdef WB_STARVE_EN
    step(0, 0, 0, 1, 1, 0, 0, 64'h1);
    chk("rst_in_force", stall_pipe, 1'b1);
`endif
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_no_write", rf_we, 1'b0);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      step($urandom_range(0, 1), 5'($urandom_range(0, 31)), {$urandom, $urandom},
           $urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), $urandom_range(0, 1),
           {$urandom, $urandom}, {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
